prt_scaler_slw_buf: RTL
=======================

PRT_SCALER_SLW_BUF -- requirements
Module: prt_scaler_slw_buf

Interface
REQ-001 SHALL have parameter P_BPC, default 8, bits per component.
REQ-002 SHALL have port CLK_IN  input  1  sole clock.
REQ-003 SHALL have port RST_IN  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port STEP_IN  input  8  output step in 1/256 input pixel; 0 means 256 (1:1).
REQ-005 SHALL have ports SRC_DAT_IN (P_BPC), SRC_VLD_IN (1), SRC_SOL_IN (1) and SRC_EOL_IN (1) as inputs carrying the pixel, its valid flag, a start-of-line flag and an end-of-line flag.
REQ-006 SHALL have port SRC_RDY_OUT  output  1  input accept; transfer when SRC_VLD_IN and SRC_RDY_OUT are both high.
REQ-007 SHALL have ports A_DAT_OUT..G_DAT_OUT  output  P_BPC each  registered window taps; A newest, G oldest.
REQ-008 SHALL have ports SEL_OUT (3) and WR_OUT (1) as outputs giving the downstream mux select and write strobe.
REQ-009 SHALL have port BUSY_OUT  output  1  high in any state other than IDLE.

Function
REQ-010 SHALL keep a 7-entry internal window W[A..G]; a shift moves A->B->...->G and loads the new pixel into A.
REQ-011 SHALL implement the FSM IDLE, FILL, RUN, FLUSH.
REQ-012 IDLE: SRC_RDY_OUT=1; accepted pixel without SOL is discarded; accepted pixel with SOL loads it into all 7 entries, latches STEP_IN, sets phase ph=0 and fill count=0, then goes to FILL.
REQ-013 FILL: SRC_RDY_OUT=1; each accepted pixel shifts the window, no output; after the 3rd shift, go to RUN (D=p0, C=p1).
REQ-014 RUN: sum = ph + step (9 bits), carry = sum[8]; SRC_RDY_OUT = carry, driven combinationally.
REQ-015 RUN: emit when !carry or (carry and pixel accepted); if carry and no pixel, stall with WR_OUT=0 and ph held.
REQ-016 On emit: WR_OUT<=1; SEL_OUT<= (ph[7] ? 2 : 3); taps<=W before any shift; ph<=sum[7:0]; if carry, shift.
REQ-017 Accepted pixel with EOL in RUN: emit and shift as normal, then go to FLUSH with flush count=0.
REQ-018 FLUSH: SRC_RDY_OUT=0; emit every cycle; a carry shifts in a copy of W.A and increments flush count; the cycle of the 4th carry shift goes to IDLE.
REQ-019 Accepted pixel with SOL in FILL or RUN aborts the line and restarts per REQ-012, with no emit that cycle.
REQ-020 EOL accepted in FILL (line shorter than 4 pixels, unsupported) goes to IDLE with no output.
REQ-021 WR_OUT SHALL be a single-cycle strobe, low in every non-emit cycle; SEL_OUT and the taps hold between emits.
REQ-022 Latency SHALL be 1 cycle from an emit decision to WR_OUT/SEL_OUT/taps; the downstream mux samples them on the next edge.
REQ-023 A line of N≥4 pixels SHALL produce ceil(N*256/step) outputs; STEP_IN=0 gives exactly N outputs p0..p(N-1).
REQ-024 STEP_IN changes mid-line SHALL be ignored until the next SOL.

Reset
REQ-025 RST_IN low SHALL asynchronously force state=IDLE, ph=0, counters=0, WR_OUT=0, SEL_OUT=0, all taps and W=0, BUSY_OUT=0; SRC_RDY_OUT follows state (1 in IDLE).
REQ-026 Reset mid-line SHALL discard the line; the first post-reset output SHALL follow a new SOL.

Structure
REQ-027 The FSM state enum, FILL count (3), FLUSH count (4) and select codes (centre 3, next 2) SHALL live in the shared package prt_scaler_slw_pkg.
REQ-028 The block SHALL need no sub-module; it instantiates next to prt_scaler_slw_mux, driving its SEL/WR/A..G inputs.
REQ-029 RTL SHALL be 120-400 lines, fully synchronous apart from the async reset.

Verification
REQ-030 STEP_IN=0, line 10,11,...,17 (8 px, SOL/EOL), VLD always 1 -> 8 WR_OUT pulses, SEL_OUT=3, D taps 10..17 in order.
REQ-031 STEP_IN=128, line 1..6 -> 12 outputs with D/SEL pairs (1,3),(1,2),(2,3),(2,2)...(6,2); SRC_RDY_OUT low on alternate RUN cycles.
REQ-032 STEP_IN=0, SRC_VLD_IN toggling 1/0 in RUN -> WR_OUT only in accept cycles, ph unchanged while stalled, same 8 outputs as REQ-030.
REQ-033 SOL at pixel 3 of a line in RUN -> restart: taps reload to the new pixel, no stale outputs, new line complete.
REQ-034 RST_IN low for 1 cycle mid-RUN -> all outputs 0 immediately, IDLE, SRC_RDY_OUT=1; non-SOL pixels are then dropped.
REQ-035 EOL on 2nd pixel (2-pixel line) -> no WR_OUT, back to IDLE, BUSY_OUT=0.

Source files
------------

// File: rtl/prt_scaler_slw_pkg.sv
// rtl/prt_scaler_slw_pkg.sv - shared FSM states, fill/flush counts and mux select codes
package prt_scaler_slw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Shifts needed after the SOL load before D holds p0 and C holds p1
    localparam logic [2:0] FILL_SHIFTS  = 3'd3;
    // Shifts after EOL that walk the last pixel through the centre tap
    localparam logic [2:0] FLUSH_SHIFTS = 3'd4;

    // Downstream mux select codes
    localparam logic [2:0] SEL_CENTRE   = 3'd3;
    localparam logic [2:0] SEL_NEXT     = 3'd2;

endpackage

// File: rtl/prt_scaler_slw_buf.sv
// rtl/prt_scaler_slw_buf.sv - 7-tap sliding window buffer driving the slow-scaler output mux
module prt_scaler_slw_buf
    import prt_scaler_slw_pkg::*;
#(
    parameter int P_BPC = 8
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic [7:0]       STEP_IN,
    input  logic [P_BPC-1:0] SRC_DAT_IN,
    input  logic             SRC_VLD_IN,
    input  logic             SRC_SOL_IN,
    input  logic             SRC_EOL_IN,
    output logic             SRC_RDY_OUT,
    output logic [P_BPC-1:0] A_DAT_OUT,
    output logic [P_BPC-1:0] B_DAT_OUT,
    output logic [P_BPC-1:0] C_DAT_OUT,
    output logic [P_BPC-1:0] D_DAT_OUT,
    output logic [P_BPC-1:0] E_DAT_OUT,
    output logic [P_BPC-1:0] F_DAT_OUT,
    output logic [P_BPC-1:0] G_DAT_OUT,
    output logic [2:0]       SEL_OUT,
    output logic             WR_OUT,
    output logic             BUSY_OUT
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_ph;
    logic [8:0]            r_step;      // 1..256, latched at SOL
    logic [2:0]            r_cnt;       // fill or flush shift count
    logic [6:0][P_BPC-1:0] r_win;       // index 0 = A (newest)
    logic [6:0][P_BPC-1:0] r_tap;
    logic [2:0]            r_sel;
    logic                  r_wr;

    logic [8:0]            w_sum;
    logic                  w_carry;
    logic                  w_rdy;
    logic                  w_acc;
    logic                  w_load;
    logic                  w_shift;
    logic                  w_emit;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;
    logic [P_BPC-1:0]      w_shift_dat;

    assign w_sum   = {1'b0, r_ph} + r_step;
    assign w_carry = w_sum[8];
    assign w_rdy   = (r_state == ST_IDLE) || (r_state == ST_FILL) ||
                     ((r_state == ST_RUN) && w_carry);
    assign w_acc   = SRC_VLD_IN && w_rdy;

    // State register
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state plus the load/shift/emit decisions for this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_emit      = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_shift_dat = SRC_DAT_IN;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && SRC_SOL_IN) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_acc) begin
                    if (SRC_SOL_IN) begin
                        w_load = 1'b1;
                    end else if (SRC_EOL_IN && (r_cnt != FILL_SHIFTS - 3'd1)) begin
                        // Lines of fewer than four pixels are dropped
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_shift   = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (r_cnt == FILL_SHIFTS - 3'd1) begin
                            // A four-pixel line ends on the last fill shift and flushes directly
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = SRC_EOL_IN ? ST_FLUSH : ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                if (w_acc && SRC_SOL_IN) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_FILL;
                end else if (!w_carry || w_acc) begin
                    w_emit  = 1'b1;
                    w_shift = w_carry;
                    if (w_acc && SRC_EOL_IN) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                w_emit      = 1'b1;
                w_shift_dat = r_win[0];
                if (w_carry) begin
                    w_shift   = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (r_cnt == FLUSH_SHIFTS - 3'd1) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Phase accumulator and per-line step latch (0 on the input means 256)
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_ph   <= '0;
            r_step <= '0;
        end else if (w_load) begin
            r_ph   <= '0;
            r_step <= (STEP_IN == 8'd0) ? 9'd256 : {1'b0, STEP_IN};
        end else if (w_emit) begin
            r_ph   <= w_sum[7:0];
        end
    end

    // Fill/flush shift counter
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN)                  r_cnt <= '0;
        else if (w_load || w_cnt_clr) r_cnt <= '0;
        else if (w_cnt_inc)           r_cnt <= r_cnt + 3'd1;
    end

    // Window: SOL replicates the pixel into every entry, otherwise shift A towards G
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN)      r_win <= '0;
        else if (w_load)  r_win <= {7{SRC_DAT_IN}};
        else if (w_shift) r_win <= {r_win[5:0], w_shift_dat};
    end

    // Registered mux outputs: taps capture the window before this cycle's shift
    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            r_wr  <= 1'b0;
            r_sel <= '0;
            r_tap <= '0;
        end else begin
            r_wr <= w_emit;
            if (w_emit) begin
                r_sel <= r_ph[7] ? SEL_NEXT : SEL_CENTRE;
                r_tap <= r_win;
            end
        end
    end

    assign SRC_RDY_OUT = w_rdy;
    assign BUSY_OUT    = (r_state != ST_IDLE);
    assign WR_OUT      = r_wr;
    assign SEL_OUT     = r_sel;
    assign A_DAT_OUT   = r_tap[0];
    assign B_DAT_OUT   = r_tap[1];
    assign C_DAT_OUT   = r_tap[2];
    assign D_DAT_OUT   = r_tap[3];
    assign E_DAT_OUT   = r_tap[4];
    assign F_DAT_OUT   = r_tap[5];
    assign G_DAT_OUT   = r_tap[6];

endmodule
